// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter sharing the 1RW data SRAM between core and Wishbone
module dram_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [3:0]        core_be_i,
  input  logic [31:0]       core_addr_i,
  input  logic [31:0]       core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [31:0]       core_rdata_o,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              sram_csb0_o,
  output logic              sram_web0_o,
  output logic [3:0]        sram_wmask0_o,
  output logic [ADDR_W-1:0] sram_addr0_o,
  output logic [31:0]       sram_din0_o,
  input  logic [31:0]       sram_dout0_i
);

  logic ready;
  logic rr_ptr;      // 0: core has priority, 1: Wishbone has priority
  logic core_pend;
  logic core_is_wr;
  logic wb_pend;
  logic wb_is_wr;

  logic core_elig;
  logic wb_elig;
  logic core_win;
  logic wb_win;

  // wb_pend masks the strobe that Wishbone keeps asserted through its ack cycle
  assign core_elig = core_req_i & ready;
  assign wb_elig   = wbs_cyc_i & wbs_stb_i & ready & ~wb_pend;
  assign core_win  = core_elig & (~wb_elig | ~rr_ptr);
  assign wb_win    = wb_elig & (~core_elig | rr_ptr);

  assign core_gnt_o    = core_win;
  assign core_rvalid_o = core_pend;
  assign core_rdata_o  = (core_pend & ~core_is_wr) ? sram_dout0_i : 32'd0;
  assign wbs_ack_o     = wb_pend;
  assign wbs_dat_o     = (wb_pend & ~wb_is_wr) ? sram_dout0_i : 32'd0;

  // Drive the SRAM port from whichever requester won this cycle
  always_comb begin
    sram_csb0_o   = 1'b1;
    sram_web0_o   = 1'b1;
    sram_wmask0_o = 4'b0000;
    sram_addr0_o  = '0;
    sram_din0_o   = 32'd0;
    if (core_win) begin
      sram_csb0_o   = 1'b0;
      sram_web0_o   = ~core_we_i;
      sram_wmask0_o = core_we_i ? core_be_i : 4'b0000;
      sram_addr0_o  = core_addr_i[ADDR_W+1:2];
      sram_din0_o   = core_wdata_i;
    end else if (wb_win) begin
      sram_csb0_o   = 1'b0;
      sram_web0_o   = ~wbs_we_i;
      sram_wmask0_o = wbs_we_i ? wbs_sel_i : 4'b0000;
      sram_addr0_o  = wbs_adr_i[ADDR_W+1:2];
      sram_din0_o   = wbs_dat_i;
    end
  end

  // Track readiness, round-robin pointer and the single-cycle completions of each port
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ready      <= 1'b0;
      rr_ptr     <= 1'b0;
      core_pend  <= 1'b0;
      core_is_wr <= 1'b0;
      wb_pend    <= 1'b0;
      wb_is_wr   <= 1'b0;
    end else begin
      ready     <= 1'b1;
      core_pend <= core_win;
      wb_pend   <= wb_win;
      if (core_win) begin
        rr_ptr     <= 1'b1;
        core_is_wr <= core_we_i;
      end else if (wb_win) begin
        rr_ptr   <= 1'b0;
        wb_is_wr <= wbs_we_i;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_rvalid;
  logic [31:0] core_rdata;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_w;
  logic        wb_ack;
  logic [31:0] wb_dat_r;
  logic        csb0, web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_W(8)) dut (
    .clk_i(clk), .rstn_i(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_be_i(core_be),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_we_i(wb_we), .wbs_sel_i(wb_sel),
    .wbs_adr_i(wb_adr), .wbs_dat_i(wb_dat_w),
    .wbs_ack_o(wb_ack), .wbs_dat_o(wb_dat_r),
    .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wmask0),
    .sram_addr0_o(addr0), .sram_din0_o(din0), .sram_dout0_i(dout0)
  );

  // 1RW SRAM macro model: masked byte writes, read data valid the cycle after access
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++)
          if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat_w = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    dout0 = 32'd0;
    rst_n = 1'b0;
    idle_inputs();
    #12;
    check("rst_csb0", {31'd0, csb0}, 32'd1);
    check("rst_web0", {31'd0, web0}, 32'd1);
    check("rst_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_rvalid", {31'd0, core_rvalid}, 32'd0);
    core_req = 1;
    #1;
    check("rst_gnt_masked", {31'd0, core_gnt}, 32'd0);

    // release; core write 0xAB610000 to word 0
    tick();
    rst_n = 1'b1;
    core_we = 1; core_be = 4'hF; core_addr = 32'h0; core_wdata = 32'hAB610000;
    #3;
    check("no_gnt_first_cycle", {31'd0, core_gnt}, 32'd0);
    tick(); #3;
    check("cw_gnt", {31'd0, core_gnt}, 32'd1);
    check("cw_csb0", {31'd0, csb0}, 32'd0);
    check("cw_web0", {31'd0, web0}, 32'd0);
    check("cw_wmask", {28'd0, wmask0}, 32'hF);
    check("cw_addr0", {24'd0, addr0}, 32'd0);
    check("cw_din0", din0, 32'hAB610000);
    tick();
    idle_inputs();
    #3;
    check("cw_rvalid", {31'd0, core_rvalid}, 32'd1);
    check("cw_rdata_zero", core_rdata, 32'd0);
    check("cw_idle_csb0", {31'd0, csb0}, 32'd1);

    // Wishbone read of word 0, strobe held through ack
    tick();
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h0;
    #3;
    check("wr_csb0", {31'd0, csb0}, 32'd0);
    check("wr_web0", {31'd0, web0}, 32'd1);
    check("wr_wmask", {28'd0, wmask0}, 32'd0);
    check("wr_ack_early", {31'd0, wb_ack}, 32'd0);
    tick(); #3;
    check("wr_ack", {31'd0, wb_ack}, 32'd1);
    check("wr_dat", wb_dat_r, 32'hAB610000);
    check("wr_no_second_access", {31'd0, csb0}, 32'd1);
    tick();
    idle_inputs();
    #3;
    check("wr_ack_drop", {31'd0, wb_ack}, 32'd0);
    check("wr_dat_zero", wb_dat_r, 32'd0);

    // prefill word 5 from the core
    core_req = 1; core_we = 1; core_be = 4'hF; core_addr = 32'h14; core_wdata = 32'h11223344;
    #3;
    check("pf_gnt", {31'd0, core_gnt}, 32'd1);
    tick();
    idle_inputs();

    // Wishbone byte write to word 5, cyc dropped during ack cycle
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_sel = 4'b0010; wb_adr = 32'h14; wb_dat_w = 32'h0000CD00;
    #3;
    check("ww_web0", {31'd0, web0}, 32'd0);
    check("ww_wmask", {28'd0, wmask0}, 32'h2);
    check("ww_addr0", {24'd0, addr0}, 32'd5);
    tick();
    idle_inputs();
    #3;
    check("ww_ack_after_cyc_drop", {31'd0, wb_ack}, 32'd1);
    check("ww_dat_zero", wb_dat_r, 32'd0);
    check("ww_csb0_idle", {31'd0, csb0}, 32'd1);

    // core read of word 5 shows merged byte
    tick();
    core_req = 1; core_we = 0; core_addr = 32'h14;
    #3;
    check("cr5_gnt", {31'd0, core_gnt}, 32'd1);
    tick();
    core_addr = 32'h400;
    #3;
    check("cr5_rvalid", {31'd0, core_rvalid}, 32'd1);
    check("cr5_rdata", core_rdata, 32'h1122CD44);
    check("wrap_addr0", {24'd0, addr0}, 32'd0);
    tick();
    idle_inputs();
    #3;
    check("wrap_rdata", core_rdata, 32'hAB610000);

    // round robin from reset with both ports requesting continuously
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    core_req = 1; core_we = 0; core_addr = 32'h4;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h8;
    #3;
    check("rr_first_no_gnt", {31'd0, csb0}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      logic exp_core;
      tick(); #3;
      exp_core = (i % 2 == 0);
      check($sformatf("rr_core_gnt%0d", i), {31'd0, core_gnt}, {31'd0, exp_core});
      check($sformatf("rr_addr%0d", i), {24'd0, addr0}, exp_core ? 32'd1 : 32'd2);
      check($sformatf("rr_ack%0d", i), {31'd0, wb_ack}, {31'd0, (i > 0) && exp_core});
    end

    // reset asserted the cycle after a core grant
    tick();
    idle_inputs();
    tick();
    core_req = 1; core_we = 0; core_addr = 32'h0;
    #3;
    check("mr_gnt", {31'd0, core_gnt}, 32'd1);
    tick();
    rst_n = 1'b0;
    #3;
    check("mr_rvalid_lost", {31'd0, core_rvalid}, 32'd0);
    check("mr_rdata", core_rdata, 32'd0);
    check("mr_csb0", {31'd0, csb0}, 32'd1);
    check("mr_gnt_low", {31'd0, core_gnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    #3;
    check("mr_first_cycle", {31'd0, core_gnt}, 32'd0);
    tick(); #3;
    check("mr_second_gnt", {31'd0, core_gnt}, 32'd1);
    tick(); #3;
    check("mr_rvalid", {31'd0, core_rvalid}, 32'd1);
    check("mr_rdata_word0", core_rdata, 32'hAB610000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
